// File: rtl/dec_pkg.sv
// Shared decode-stage constants: optype and compare encodings,
// RV32I major opcodes and the packed decode bus width.
package dec_pkg;

  localparam int DQ_XLEN  = 32;
  localparam int DQ_BUS_W = 6 * DQ_XLEN + 51;

  localparam logic [2:0] INST_NONE = 3'b000;
  localparam logic [2:0] INST_R    = 3'b001;
  localparam logic [2:0] INST_I    = 3'b010;
  localparam logic [2:0] INST_S    = 3'b011;
  localparam logic [2:0] INST_B    = 3'b100;
  localparam logic [2:0] INST_U    = 3'b101;
  localparam logic [2:0] INST_J    = 3'b110;
  localparam logic [2:0] INST_PRIV = 3'b111;

  localparam logic [2:0] CMP_EQ   = 3'b000;
  localparam logic [2:0] CMP_NE   = 3'b001;
  localparam logic [2:0] CMP_GE   = 3'b010;
  localparam logic [2:0] CMP_LT   = 3'b011;
  localparam logic [2:0] CMP_LTU  = 3'b101;
  localparam logic [2:0] CMP_GEU  = 3'b110;
  localparam logic [2:0] CMP_NONE = 3'b111;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  // Branch funct3 to compare fn; reserved funct3 never takes.
  function automatic logic [2:0] br_fn(input logic [2:0] f3);
    logic [2:0] fn;
    fn = CMP_NONE;
    case (f3)
      3'b000:  fn = CMP_EQ;
      3'b001:  fn = CMP_NE;
      3'b100:  fn = CMP_LT;
      3'b101:  fn = CMP_GE;
      3'b110:  fn = CMP_LTU;
      3'b111:  fn = CMP_GEU;
      default: fn = CMP_NONE;
    endcase
    return fn;
  endfunction

endpackage

// File: rtl/compare.sv
// Shared comparator used by branch resolution and set-less-than.
// Unknown fn codes report false.
module compare
  import dec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      fn,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            result
);

  // Evaluate the selected relation on the two operands.
  always_comb begin
    result = 1'b0;
    case (fn)
      CMP_EQ:  result = (src1 == src2);
      CMP_NE:  result = (src1 != src2);
      CMP_LT:  result = ($signed(src1) < $signed(src2));
      CMP_GE:  result = ($signed(src1) >= $signed(src2));
      CMP_LTU: result = (src1 < src2);
      CMP_GEU: result = (src1 >= src2);
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/inst_queue.sv
// Circular FIFO with occupancy count and single-cycle flush.
// A full queue refuses pushes even when popping.
module inst_queue #(
  parameter  int DEPTH = 4,
  parameter  int W     = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [PTR_W:0] count
);

  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic             empty;

  assign empty     = (count == '0);
  assign in_ready  = ~reset & (count != FULL);
  assign out_valid = ~reset & ~empty & ~flush;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  // Empty head reads as zero so downstream decode never sees X.
  assign out_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy update; flush drops everything queued.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W + 1)'(push)
                     - (PTR_W + 1)'(pop);
    end
  end

  // Entry storage, deliberately not reset.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/dec_queue.sv
// Decode stage: buffered fetch queue feeding a combinational
// decoder that resolves branch and set-less-than compares.
module dec_queue
  import dec_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_snpc,
  input  logic [31:0]       in_inst,
  input  logic              flush,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  input  logic [XLEN-1:0]   rs1_value_i,
  input  logic [XLEN-1:0]   rs2_value_i,
  output logic [11:0]       csr_addr_o,
  input  logic [XLEN-1:0]   csr_value_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [6*XLEN+50:0] out_bus,
  output logic [PTR_W:0]    count_o
);

  localparam int PW = 2 * XLEN + 32;

  logic [PW-1:0]   head;
  logic [XLEN-1:0] hd_pc;
  logic [XLEN-1:0] hd_snpc;
  logic [31:0]     inst;

  inst_queue #(
    .DEPTH (DEPTH),
    .W     (PW)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_pc, in_snpc, in_inst}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head),
    .count     (count_o)
  );

  assign {hd_pc, hd_snpc, inst} = head;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  assign opcode     = inst[6:0];
  assign funct3     = inst[14:12];
  assign funct7     = inst[31:25];
  assign rd         = inst[11:7];
  assign rs1_o      = inst[19:15];
  assign rs2_o      = inst[24:20];
  assign csr_addr_o = inst[31:20];

  logic is_r, is_s, is_b, is_j, is_u, is_i, is_sys;

  assign is_r   = (opcode == OP_R);
  assign is_s   = (opcode == OP_S);
  assign is_b   = (opcode == OP_B);
  assign is_j   = (opcode == OP_JAL);
  assign is_u   = (opcode == OP_LUI) | (opcode == OP_AUIPC);
  assign is_i   = (opcode == OP_IMM) | (opcode == OP_LOAD)
                | (opcode == OP_JALR);
  assign is_sys = (opcode == OP_SYS);

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25],
                  inst[11:7]};
  assign imm_b = {{(XLEN-12){inst[31]}}, inst[7],
                  inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
  assign imm_j = {{(XLEN-20){inst[31]}}, inst[19:12],
                  inst[20], inst[30:21], 1'b0};

  logic [2:0]      optype;
  logic [XLEN-1:0] imm;
  logic            illegal;

  // Classify the head opcode and pick its immediate format.
  always_comb begin
    optype  = INST_NONE;
    imm     = '0;
    illegal = 1'b0;
    unique case (1'b1)
      is_r:   optype = INST_R;
      is_i:   begin optype = INST_I; imm = imm_i; end
      is_s:   begin optype = INST_S; imm = imm_s; end
      is_b:   begin optype = INST_B; imm = imm_b; end
      is_u:   begin optype = INST_U; imm = imm_u; end
      is_j:   begin optype = INST_J; imm = imm_j; end
      is_sys: optype = INST_PRIV;
      default: illegal = 1'b1;
    endcase
  end

  logic is_slt, is_sltu, is_slti, is_sltiu;

  assign is_slt   = is_r & (funct7 == 7'd0)
                  & (funct3 == 3'b010);
  assign is_sltu  = is_r & (funct7 == 7'd0)
                  & (funct3 == 3'b011);
  assign is_slti  = (opcode == OP_IMM) & (funct3 == 3'b010);
  assign is_sltiu = (opcode == OP_IMM) & (funct3 == 3'b011);

  logic [2:0] cmp_fn;

  // Choose the relation: branch funct3 or set-less-than flavour.
  always_comb begin
    cmp_fn = CMP_NONE;
    unique case (1'b1)
      is_b:               cmp_fn = br_fn(funct3);
      is_slt | is_slti:   cmp_fn = CMP_LT;
      is_sltu | is_sltiu: cmp_fn = CMP_LTU;
      default:            cmp_fn = CMP_NONE;
    endcase
  end

  logic [XLEN-1:0] cmp_src2;
  logic            cmp_result;
  logic            br_taken;
  logic            res_from_compare;

  assign cmp_src2 = (is_slti | is_sltiu) ? imm : rs2_value_i;

  compare #(
    .XLEN (XLEN)
  ) u_compare (
    .fn     (cmp_fn),
    .src1   (rs1_value_i),
    .src2   (cmp_src2),
    .result (cmp_result)
  );

  assign br_taken         = is_b & cmp_result;
  assign res_from_compare = is_slt | is_sltu | is_slti | is_sltiu;

  assign out_bus = {res_from_compare, cmp_result, hd_snpc, hd_pc,
                    imm, rs1_value_i, rs2_value_i, rs1_o, rs2_o,
                    rd, br_taken, csr_addr_o, csr_value_i, optype,
                    opcode, funct3, funct7, illegal};

endmodule

// File: tb/tb_dec_queue.sv
// Directed plus random bench for dec_queue against a queue-based
// reference model of occupancy, ordering and RV32I decode.
module tb_dec_queue;
  import dec_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_snpc;
  logic [31:0] in_inst;
  logic        flush;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [31:0] rs1_value_i;
  logic [31:0] rs2_value_i;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_value_i;
  logic        out_valid;
  logic        out_ready;
  logic [6*XLEN+50:0] out_bus;
  logic [2:0]  count_o;

  dec_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_snpc     (in_snpc),
    .in_inst     (in_inst),
    .flush       (flush),
    .rs1_o       (rs1_o),
    .rs2_o       (rs2_o),
    .rs1_value_i (rs1_value_i),
    .rs2_value_i (rs2_value_i),
    .csr_addr_o  (csr_addr_o),
    .csr_value_i (csr_value_i),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_bus     (out_bus),
    .count_o     (count_o)
  );

  typedef struct packed {
    logic        res_cmp;
    logic        cmp;
    logic [31:0] snpc;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        br;
    logic [11:0] csr_addr;
    logic [31:0] csr_val;
    logic [2:0]  optype;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        illegal;
  } bus_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] snpc;
    logic [31:0] inst;
  } entry_t;

  bus_t   b;
  entry_t mq[$];
  int     checks = 0;
  int     fails  = 0;

  assign b = out_bus;

  logic [6:0] ops [10] = '{7'b0110011, 7'b0100011, 7'b1100011,
                           7'b1101111, 7'b0110111, 7'b0010111,
                           7'b0010011, 7'b0000011, 7'b1100111,
                           7'b1110011};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] m_optype(input logic [31:0] i);
    case (i[6:0])
      7'b0110011: return INST_R;
      7'b0100011: return INST_S;
      7'b1100011: return INST_B;
      7'b1101111: return INST_J;
      7'b0110111, 7'b0010111: return INST_U;
      7'b0010011, 7'b0000011, 7'b1100111: return INST_I;
      7'b1110011: return INST_PRIV;
      default: return INST_NONE;
    endcase
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] i);
    int s;
    s = int'(i);
    case (m_optype(i))
      INST_I: return 32'(s >>> 20);
      INST_S: return 32'((s >>> 25) * 32) | {27'b0, i[11:7]};
      INST_B: return 32'((s >>> 31) * 4096)
                   | {20'b0, i[7], i[30:25], i[11:8], 1'b0};
      INST_U: return i & 32'hFFFFF000;
      INST_J: return 32'((s >>> 31) * (1 << 20))
                   | {12'b0, i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_cmp(input logic [31:0] i, input logic [31:0] a,
                       input logic [31:0] r2, output logic rel,
                       output logic cmp, output logic br,
                       output logic resc);
    logic [31:0] o2;
    rel = 0; cmp = 0; br = 0; resc = 0;
    if (i[6:0] == 7'b1100011) begin
      rel = 1;
      case (i[14:12])
        3'b000: cmp = (a == r2);
        3'b001: cmp = (a != r2);
        3'b100: cmp = ($signed(a) < $signed(r2));
        3'b101: cmp = ($signed(a) >= $signed(r2));
        3'b110: cmp = (a < r2);
        3'b111: cmp = (a >= r2);
        default: cmp = 0;
      endcase
      br = cmp;
    end else if ((i[14:12] == 3'b010 || i[14:12] == 3'b011) &&
                 ((i[6:0] == 7'b0110011 && i[31:25] == 7'd0) ||
                   i[6:0] == 7'b0010011)) begin
      rel  = 1;
      resc = 1;
      o2   = (i[6:0] == 7'b0010011) ? m_imm(i) : r2;
      cmp  = (i[14:12] == 3'b010) ? ($signed(a) < $signed(o2))
                                  : (a < o2);
    end
  endtask

  task automatic check_all();
    entry_t e;
    logic rel, cmp, br, resc;
    chk("count", count_o, mq.size());
    chk("in_ready", in_ready, mq.size() != DEPTH);
    chk("out_valid", out_valid, mq.size() != 0 && !flush);
    if (mq.size() != 0) begin
      e = mq[0];
      m_cmp(e.inst, rs1_value_i, rs2_value_i, rel, cmp, br, resc);
      chk("pc", b.pc, e.pc);
      chk("snpc", b.snpc, e.snpc);
      chk("optype", b.optype, m_optype(e.inst));
      chk("imm", b.imm, m_imm(e.inst));
      chk("illegal", b.illegal, m_optype(e.inst) == INST_NONE);
      chk("rd", b.rd, e.inst[11:7]);
      chk("rs1_o", rs1_o, e.inst[19:15]);
      chk("rs2_o", rs2_o, e.inst[24:20]);
      chk("csr_addr", csr_addr_o, e.inst[31:20]);
      chk("csr_val", b.csr_val, csr_value_i);
      chk("rs1_val", b.rs1_val, rs1_value_i);
      chk("br_taken", b.br, br);
      chk("res_cmp", b.res_cmp, resc);
      if (rel) chk("cmp_result", b.cmp, cmp);
    end
  endtask

  task automatic step();
    logic push, pop;
    #1;
    check_all();
    push = in_valid && mq.size() < DEPTH && !flush;
    pop  = mq.size() != 0 && !flush && out_ready;
    @(posedge clock);
    #1;
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(entry_t'{in_pc, in_snpc, in_inst});
    end
  endtask

  task automatic run_inst(input logic [31:0] i, input logic [31:0] r1,
                          input logic [31:0] r2);
    rs1_value_i = r1;
    rs2_value_i = r2;
    in_valid = 1; in_inst = i; out_ready = 0;
    in_pc = 32'h80001000; in_snpc = 32'h80001004;
    step();
    in_valid = 0;
    #1;
  endtask

  task automatic pop_one();
    out_ready = 1;
    step();
    out_ready = 0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] i;
    i = $urandom;
    if ($urandom_range(0, 9) != 0) i[6:0] = ops[$urandom_range(0, 9)];
    if (i[6:0] == 7'b0110011 && $urandom_range(0, 1) == 1)
      i[31:25] = 7'd0;
    return i;
  endfunction

  initial begin
    logic [31:0] ins;
    reset = 1; in_valid = 0; in_pc = 0; in_snpc = 0; in_inst = 0;
    flush = 0; out_ready = 0; rs1_value_i = 0; rs2_value_i = 0;
    csr_value_i = 0;
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("in_ready_in_reset", in_ready, 0);
    chk("out_valid_in_reset", out_valid, 0);
    reset = 0;
    mq.delete();
    step();

    // Fill to full with the ADU stalled.
    for (int k = 0; k < DEPTH; k++) begin
      in_valid = 1;
      in_pc    = 32'h80000000 + 32'(4 * k);
      in_snpc  = in_pc + 4;
      in_inst  = rand_inst();
      step();
    end
    in_pc = 32'h80000010; in_snpc = 32'h80000014;
    in_inst = rand_inst();
    step();
    chk("fifth_not_accepted", count_o, 4);
    chk("head_first_pc", b.pc, 32'h80000000);

    // Full + pop: pop only, then the push goes in.
    out_ready = 1;
    step();
    chk("full_pop_only", count_o, 3);
    step();
    in_valid = 0;
    for (int k = 0; k < DEPTH + 1; k++) step();
    out_ready = 0;
    step();

    run_inst(32'h00208463, 32'd5, 32'd5);
    chk("beq_br_taken", b.br, 1);
    chk("beq_cmp", b.cmp, 1);
    pop_one();
    run_inst(32'h0020E463, 32'hFFFFFFFF, 32'd1);
    chk("bltu_br_taken", b.br, 0);
    pop_one();
    ins = {12'hFFF, 5'd1, 3'b010, 5'd3, 7'b0010011};
    run_inst(ins, 32'hFFFFFFFE, 32'd0);
    chk("slti_res_cmp", b.res_cmp, 1);
    chk("slti_cmp", b.cmp, 1);
    pop_one();
    ins = {12'hFFF, 5'd1, 3'b011, 5'd3, 7'b0010011};
    run_inst(ins, 32'hFFFFFFFE, 32'd0);
    chk("sltiu_cmp", b.cmp, 1);
    pop_one();
    run_inst(32'h0000007F, 32'd0, 32'd0);
    chk("illegal_flag", b.illegal, 1);
    chk("illegal_optype", b.optype, 0);
    chk("illegal_imm", b.imm, 0);
    pop_one();
    run_inst(32'h800000EF, 32'd0, 32'd0);
    chk("jal_imm", b.imm, 32'hFFF00000);
    ins = b.imm;
    chk("jal_imm_bit0", ins[0], 0);
    pop_one();

    // Flush with three queued and a push in the same cycle.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_pc = 32'h90000000 + 32'(4 * k);
      in_snpc = in_pc + 4; in_inst = rand_inst();
      step();
    end
    in_pc = 32'hDEAD0000; flush = 1;
    step();
    flush = 0; in_valid = 0;
    #1;
    chk("flush_count", count_o, 0);
    chk("flush_out_valid", out_valid, 0);
    step();
    in_valid = 1; in_pc = 32'hA0000000; in_snpc = 32'hA0000004;
    step();
    in_valid = 0;
    #1;
    chk("after_flush_pc", b.pc, 32'hA0000000);
    pop_one();

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      in_valid    = $urandom_range(0, 3) != 0;
      out_ready   = $urandom_range(0, 2) != 0;
      flush       = $urandom_range(0, 24) == 0;
      in_pc       = $urandom;
      in_snpc     = in_pc + 4;
      in_inst     = rand_inst();
      rs1_value_i = $urandom;
      case ($urandom_range(0, 2))
        0: rs2_value_i = rs1_value_i;
        1: rs2_value_i = rs1_value_i + 32'($urandom_range(0, 2)) - 1;
        default: rs2_value_i = $urandom;
      endcase
      csr_value_i = $urandom;
      step();
    end
    flush = 0; in_valid = 0; out_ready = 1;
    for (int k = 0; k < DEPTH + 1; k++) step();
    #1;
    chk("drained", count_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
